// File: rtl/shift_counter_pkg.sv
`default_nettype none
// ============================================================================
// shift_counter_pkg : shared mode codes and sequence helpers for shift_counter_gen
// Revision: 1.0
// ============================================================================
package shift_counter_pkg;

    localparam int MODE_JOHNSON = 0;
    localparam int MODE_RING    = 1;

    function automatic int seq_len(input int width, input int mode);
        return (mode == MODE_RING) ? width : 2 * width;
    endfunction

    // Only the low 'width' bits are meaningful; callers truncate.
    function automatic logic [31:0] reset_pattern(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_counter_classify.sv
`default_nettype none
// ============================================================================
// shift_counter_classify : checks a value against the legal sequence and returns its phase
// Revision: 1.0
// ============================================================================
module shift_counter_classify
    import shift_counter_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int MODE  = MODE_JOHNSON,
    localparam int PW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] val_i,
    output logic             legal_o,
    output logic [PW-1:0]    phase_o
);

    localparam int               N       = seq_len(WIDTH, MODE);
    localparam logic [WIDTH-1:0] RST_PAT = WIDTH'(reset_pattern(WIDTH));

    // Walk the whole sequence from the reset pattern; every entry is distinct.
    always_comb begin
        logic [WIDTH-1:0] pat;
        legal_o = 1'b0;
        phase_o = '0;
        pat     = RST_PAT;
        for (int k = 0; k < N; k++) begin
            if (val_i == pat) begin
                legal_o = 1'b1;
                phase_o = PW'(k);
            end
            if (MODE == MODE_RING) begin
                pat = {pat[WIDTH-2:0], pat[WIDTH-1]};
            end else begin
                pat = {pat[WIDTH-2:0], ~pat[WIDTH-1]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_counter_gen.sv
`default_nettype none
// ============================================================================
// shift_counter_gen : Johnson/ring sequence counter with load, direction, phase, wrap and error
// Revision: 1.0
// ============================================================================
module shift_counter_gen
    import shift_counter_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int MODE  = MODE_JOHNSON,
    localparam int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    localparam int               N       = seq_len(WIDTH, MODE);
    localparam logic [WIDTH-1:0] RST_PAT = WIDTH'(reset_pattern(WIDTH));
    localparam logic [PW-1:0]    LAST_PH = PW'(N - 1);

    logic [WIDTH-1:0] q_q, q_d, step_val, cls_q_val;
    logic [PW-1:0]    phase_q, phase_d, cur_phase, ld_phase;
    logic             wrap_q, wrap_d, err_q, err_d;
    logic             cur_legal, ld_legal;

    assign cls_q_val = q_q;

    shift_counter_classify #(.WIDTH(WIDTH), .MODE(MODE)) u_cls_q (
        .val_i   (cls_q_val),
        .legal_o (cur_legal),
        .phase_o (cur_phase)
    );

    shift_counter_classify #(.WIDTH(WIDTH), .MODE(MODE)) u_cls_ld (
        .val_i   (load_val),
        .legal_o (ld_legal),
        .phase_o (ld_phase)
    );

    always_comb begin
        if (MODE == MODE_RING) begin
            step_val = dir ? {q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        end else begin
            step_val = dir ? {~q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        end
    end

    // Phase steps from the decoded q so a corrupted phase register cannot persist.
    always_comb begin
        q_d     = q_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if (ld_legal) begin
                q_d     = load_val;
                phase_d = ld_phase;
            end else begin
                q_d     = RST_PAT;
                phase_d = '0;
                err_d   = 1'b1;
            end
        end else if (en) begin
            if (!cur_legal) begin
                q_d     = RST_PAT;
                phase_d = '0;
                err_d   = 1'b1;
            end else begin
                q_d = step_val;
                if (!dir) begin
                    wrap_d  = (cur_phase == LAST_PH);
                    phase_d = wrap_d ? '0 : cur_phase + 1'b1;
                end else begin
                    wrap_d  = (cur_phase == '0);
                    phase_d = wrap_d ? LAST_PH : cur_phase - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= RST_PAT;
            phase_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign q     = q_q;
    assign phase = phase_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_counter_gen.sv
`default_nettype none
// ============================================================================
// tb_shift_counter_gen : directed checks of a Johnson W=4 and a ring W=5 instance
// Revision: 1.0
// ============================================================================
module tb_shift_counter_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, dir_a, load_a;
    logic [3:0] load_val_a, q_a;
    logic [2:0] phase_a;
    logic       wrap_a, err_a;
    logic       en_b, dir_b, load_b;
    logic [4:0] load_val_b, q_b;
    logic [3:0] phase_b;
    logic       wrap_b, err_b;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] jq  [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [4:0] rq  [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

    shift_counter_gen #(.WIDTH(4), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .dir(dir_a), .load(load_a), .load_val(load_val_a),
        .q(q_a), .phase(phase_a), .wrap(wrap_a), .err(err_a)
    );

    shift_counter_gen #(.WIDTH(5), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .dir(dir_b), .load(load_b), .load_val(load_val_b),
        .q(q_b), .phase(phase_b), .wrap(wrap_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_a(input string tag, input logic [3:0] eq, input logic [2:0] ep,
                           input logic ew, input logic ee);
        check({tag, ".q"}, 32'(q_a), 32'(eq));
        check({tag, ".phase"}, 32'(phase_a), 32'(ep));
        check({tag, ".wrap"}, 32'(wrap_a), 32'(ew));
        check({tag, ".err"}, 32'(err_a), 32'(ee));
    endtask

    task automatic check_b(input string tag, input logic [4:0] eq, input logic [3:0] ep,
                           input logic ew, input logic ee);
        check({tag, ".q"}, 32'(q_b), 32'(eq));
        check({tag, ".phase"}, 32'(phase_b), 32'(ep));
        check({tag, ".wrap"}, 32'(wrap_b), 32'(ew));
        check({tag, ".err"}, 32'(err_b), 32'(ee));
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b0; dir_a = 1'b0; load_a = 1'b0; load_val_a = '0;
        en_b = 1'b0; dir_b = 1'b0; load_b = 1'b0; load_val_b = '0;
        @(negedge clk);
        check_a("reset_a", 4'b1000, 3'd0, 1'b0, 1'b0);
        check_b("reset_b", 5'b10000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Johnson forward through the full sequence
        en_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_a($sformatf("jfwd%0d", i), jq[i], 3'((i + 1) % 8), (i == 7), 1'b0);
        end

        // Johnson reverse from the reset pattern
        dir_a = 1'b1;
        tick();
        check_a("jrev0", 4'b1100, 3'd7, 1'b1, 1'b0);
        tick();
        check_a("jrev1", 4'b1110, 3'd6, 1'b0, 1'b0);

        // Enable gating: 1,0,0,1 after a fresh reset
        dir_a = 1'b0; en_a = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en_a = 1'b1; tick(); check_a("en1", 4'b0000, 3'd1, 1'b0, 1'b0);
        en_a = 1'b0; tick(); check_a("en0a", 4'b0000, 3'd1, 1'b0, 1'b0);
        tick();              check_a("en0b", 4'b0000, 3'd1, 1'b0, 1'b0);
        en_a = 1'b1; tick(); check_a("en1b", 4'b0001, 3'd2, 1'b0, 1'b0);

        // Parallel load: legal, illegal, then load beating en
        en_a = 1'b0; load_a = 1'b1; load_val_a = 4'b0111;
        tick(); check_a("ld_legal", 4'b0111, 3'd4, 1'b0, 1'b0);
        load_val_a = 4'b0101;
        tick(); check_a("ld_illegal", 4'b1000, 3'd0, 1'b0, 1'b1);
        load_a = 1'b0;
        tick(); check_a("ld_errclr", 4'b1000, 3'd0, 1'b0, 1'b0);
        load_a = 1'b1; en_a = 1'b1; load_val_a = 4'b1110;
        tick(); check_a("ld_over_en", 4'b1110, 3'd6, 1'b0, 1'b0);
        en_a = 1'b0; load_val_a = 4'b0111;
        tick(); check_a("ld_0111", 4'b0111, 3'd4, 1'b0, 1'b0);
        load_a = 1'b0;

        // Asynchronous reset between edges, held across an edge with load
        #2 rst = 1'b1;
        #1;
        check_a("async_rst", 4'b1000, 3'd0, 1'b0, 1'b0);
        load_a = 1'b1; load_val_a = 4'b0011;
        @(negedge clk);
        check_a("rst_over_ld", 4'b1000, 3'd0, 1'b0, 1'b0);
        rst = 1'b0; load_a = 1'b0; en_a = 1'b1;
        tick(); check_a("post_rst", 4'b0000, 3'd1, 1'b0, 1'b0);
        en_a = 1'b0;

        // Ring W=5 forward through the full sequence
        en_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_b($sformatf("rfwd%0d", i), rq[i], 4'((i + 1) % 5), (i == 4), 1'b0);
        end

        // Corrupted state seen by the counter is corrected without stepping
        force dut_b.cls_q_val = 5'b00110;
        tick();
        release dut_b.cls_q_val;
        en_b = 1'b0;
        check_b("ring_fix", 5'b10000, 4'd0, 1'b0, 1'b1);

        dir_b = 1'b1; en_b = 1'b1;
        tick(); check_b("ring_rev", 5'b01000, 4'd4, 1'b1, 1'b0);
        en_b = 1'b0;
        tick(); check_b("ring_hold", 5'b01000, 4'd4, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_counter_gen.md
Name: shift_counter_gen

Overview:
Parametrised shift-register sequence counter with a selectable Johnson (twisted-ring) or ring mode. Adds several features to the fixed 4-bit Johnson counter:
- clock enable
- bidirectional stepping
- parallel load
- binary phase output
- wrap pulse
- illegal-state self-correction with an error flag

Serves as the sequencing and timing-phase generator for downstream blocks that need glitch-free decoded phases.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..32.
- MODE, 0, 0 = Johnson (sequence length N = 2*WIDTH), 1 = ring (N = WIDTH).
- Derived (localparam, not overridable): PW = $clog2(2*WIDTH), the phase output width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  advance one step this cycle
- dir  input  1  0 = forward, 1 = reverse
- load  input  1  parallel load request; priority over en
- load_val  input  WIDTH  value for load
- q  output  WIDTH  counter state, registered
- phase  output  PW  registered index of q in the sequence, 0..N-1
- wrap  output  1  registered one-cycle pulse on sequence wrap
- err  output  1  registered one-cycle pulse on illegal value detection

Behaviour:
- Reset pattern R: bit WIDTH-1 = 1, all other bits 0 (W=4: 1000).
- While rst=1, asynchronously: q=R, phase=0, wrap=0, err=0. Reset mid-operation overrides everything, including load.
- Forward step, Johnson: q[0]<=~q[W-1], q[i]<=q[i-1].
- Reverse step, Johnson: q[W-1]<=~q[0], q[i]<=q[i+1].
- Forward step, ring: rotate left, q[0]<=q[W-1]. Reverse step, ring: rotate right.
- phase = number of forward steps from R to reach q.
  - Johnson W=4, phases 0..7: 1000, 0000, 0001, 0011, 0111, 1111, 1110, 1100.
  - Ring W=4, phases 0..3: 1000, 0001, 0010, 0100.
- phase updates in the same edge as q, with zero latency relative to q.
- Legal set, Johnson: the 2W patterns of the form 0..01..1 or 1..10..0.
- Legal set, ring: exactly one bit set (one-hot).
- Priority per edge: load > en > hold.
- load=1, load_val legal: q<=load_val and phase<=its index. wrap=0, err=0.
- load=1, load_val illegal: q<=R, phase<=0, err=1 for one cycle.
- en=1, load=0, q legal: step in direction dir. phase becomes (phase±1) mod N.
- en=1, load=0, q illegal (e.g. SEU/force): q<=R, phase<=0, err=1, no step.
- wrap=1 for one cycle, aligned with the q update, in exactly two cases: a forward step moves phase from N-1 to 0, or a reverse step moves it from 0 to N-1.
- wrap is never asserted by load or by correction.
- en=0, load=0: q, phase hold; wrap=0, err=0.
- dir may change on any cycle; the change takes effect on that cycle's step.
- All outputs come directly from flops; no combinational path from inputs to outputs.

Decomposition:
- Package shift_counter_pkg:
  - MODE_JOHNSON=0, MODE_RING=1.
  - Function seq_len(width, mode) returning N.
  - Function reset_pattern(width).
- One combinational sub-module, shift_counter_classify (WIDTH, MODE).
  - Input: a WIDTH-bit value.
  - Outputs: legal flag and phase index.
  - Instantiated twice: once on q, once on load_val.

Test Plan:
- Johnson W=4, reset then hold en=1 for 8 cycles:
  - q follows 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - phase follows 1..7, 0.
  - wrap=1 only on the 8th edge.
- Johnson W=4, dir=1 from reset, one step: q=1100, phase=7, wrap=1. Next step: q=1110, phase=6, wrap=0.
- en toggled 1,0,0,1 from reset: q=0000, held for two cycles, then 0001. wrap=0, err=0 throughout.
- Load legal, then load illegal:
  - load=1, load_val=0111: q=0111, phase=4, err=0.
  - load=1, load_val=0101: q=1000, phase=0, err=1 for exactly one cycle.
  - load and en asserted together: load wins.
- Ring W=5, MODE=1, 5 forward steps:
  - q follows 00001, 00010, 00100, 01000, 10000.
  - wrap=1 on the 5th step.
  - force q=00110, then en=1: q=10000, err=1.
- Async reset mid-sequence:
  - With q=0111, assert rst between clock edges: q=1000, phase=0 immediately, with no clock edge.
  - rst held across an edge with load=1: load ignored.
  - First edge after release with en=1: q=0000.
